imm_gen_pipe: RTL

// Registered, handshaked immediate generator for the decode stage. Supports all five RV32I

---
 rtl/imm_gen_pipe.sv | 66 ++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I immediate generator feeding a 2-entry FIFO output buffer
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           imm_src,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_ext,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);
  logic [XLEN-1:0]      imm_q [2];
  logic [TAG_WIDTH-1:0] tag_q [2];
  logic [1:0]           ill_q;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic signed [31:0]   imm32;
  logic [XLEN-1:0]      dec;
  logic                 dec_ill, push, pop, s, unused_opcode;
  assign s = instr[31];
  assign unused_opcode = ^instr[6:0];
  always_comb begin
    dec_ill = imm_src > 3'd4;
    imm32 = imm_src == 3'd0 ? {{20{s}}, instr[31:20]} :
            imm_src == 3'd1 ? {{20{s}}, instr[31:25], instr[11:7]} :
            imm_src == 3'd2 ? {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            imm_src == 3'd3 ? {instr[31:12], 12'b0} :
            imm_src == 3'd4 ? {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'sd0;
    dec = XLEN'(imm32);
  end
  assign in_ready    = count != 2'd2;
  assign out_valid   = count != 2'd0;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign imm_ext     = out_valid ? imm_q[rd_ptr] : '0;
  assign out_tag     = out_valid ? tag_q[rd_ptr] : '0;
  assign out_illegal = out_valid && ill_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (push) begin
        imm_q[wr_ptr] <= dec;
        tag_q[wr_ptr] <= in_tag;
        ill_q[wr_ptr] <= dec_ill;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
      if (push && dec_ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule
